// File: rtl/layer_test_pkg.sv
// Shared types and constants for the layer self-test sequencer.
package layer_test_pkg;

    localparam int unsigned DEF_WORD_W    = 32;
    localparam int unsigned DEF_NUM_WORDS = 8;
    localparam int unsigned DEF_TIMEOUT   = 1024;
    localparam logic [31:0] DEF_HEADER    = 32'hA5A5_5A5A;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_RECV,
        ST_TEST,
        ST_XMIT,
        ST_FIN
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Counter/index width that never collapses to zero bits.
    function automatic int unsigned cnt_w(input int unsigned v);
        return (v > 1) ? clog2(v) : 1;
    endfunction

endpackage

// File: rtl/layer_test_seq_if.sv
// Link-path handshake bundle between the sequencer (master) and its
// deserializer / self-test engine / serializer neighbours (slave).
interface layer_test_seq_if #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned NUM_WORDS = 8
) ();
    localparam int unsigned IDX_W = layer_test_pkg::cnt_w(NUM_WORDS);

    logic              f_layer;
    logic [WORD_W-1:0] des_word;
    logic              sort_finish;
    logic              st_load;
    logic              st_start;
    logic              ser_load;
    logic              ser_en;
    logic              busy;
    logic              done;
    logic              err_timeout;
    logic [IDX_W-1:0]  word_idx;

    modport master (
        input  f_layer, des_word, sort_finish,
        output st_load, st_start, ser_load, ser_en, busy, done, err_timeout, word_idx
    );

    modport slave (
        output f_layer, des_word, sort_finish,
        input  st_load, st_start, ser_load, ser_en, busy, done, err_timeout, word_idx
    );
endinterface

// File: rtl/layer_bit_cnt.sv
// Modulo-WORD_W bit counter with a wrap strobe on the last bit of a word.
module layer_bit_cnt import layer_test_pkg::*; #(
    parameter int unsigned WORD_W = 32,
    localparam int unsigned CNT_W = cnt_w(WORD_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap_c
);
    assign wrap_c = (cnt == CNT_W'(WORD_W - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap_c ? '0 : cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/layer_test_seq.sv
// Frame sequencer: header hunt, payload load, self-test run, result transmit.
// Optional TEST timeout enabled by defining LAYER_SEQ_TIMEOUT_EN.
module layer_test_seq import layer_test_pkg::*; #(
    parameter int unsigned WORD_W    = DEF_WORD_W,
    parameter int unsigned NUM_WORDS = DEF_NUM_WORDS,
`ifdef LAYER_SEQ_TIMEOUT_EN
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
`endif
    parameter logic [WORD_W-1:0] HEADER = WORD_W'(DEF_HEADER)
) (
    input logic              clk,
    input logic              rst,
    layer_test_seq_if.master bus
);
    localparam int unsigned      CNT_W    = cnt_w(WORD_W);
    localparam int unsigned      IDX_W    = cnt_w(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic             f_lat_q, f_lat_d;
    logic             first_q, first_d;
    logic             busy_q, done_q, ser_en_q;
    logic [CNT_W-1:0] bit_cnt;
    logic             wrap_c, cnt_clr_c, cnt_en_c;
    logic             hdr_hit_c, sf_take_c;

`ifdef LAYER_SEQ_TIMEOUT_EN
    localparam int unsigned TMO_W = cnt_w(TIMEOUT);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
`endif

    layer_bit_cnt #(.WORD_W(WORD_W)) u_bit_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr_c),
        .en     (cnt_en_c),
        .cnt    (bit_cnt),
        .wrap_c (wrap_c)
    );

    assign hdr_hit_c = (bus.des_word == HEADER);
    // A finish seen alongside st_start belongs to no run we launched.
    assign sf_take_c = bus.sort_finish && !first_q;

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        f_lat_d    = f_lat_q;
        first_d    = 1'b0;
        cnt_clr_c  = 1'b1;
        cnt_en_c   = 1'b0;
`ifdef LAYER_SEQ_TIMEOUT_EN
        err_d      = err_q;
        tmo_d      = '0;
`endif
        case (state_q)
            ST_HUNT: begin
                if (hdr_hit_c) begin
                    state_d    = ST_RECV;
                    word_idx_d = '0;
                    f_lat_d    = bus.f_layer;
`ifdef LAYER_SEQ_TIMEOUT_EN
                    err_d      = 1'b0;
`endif
                end
            end
            ST_RECV: begin
                cnt_clr_c = 1'b0;
                cnt_en_c  = 1'b1;
                if (wrap_c) begin
                    if (word_idx_q == LAST_IDX) begin
                        state_d    = ST_TEST;
                        word_idx_d = '0;
                        first_d    = 1'b1;
                    end else begin
                        word_idx_d = word_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_TEST: begin
                if (sf_take_c) begin
                    state_d = f_lat_q ? ST_FIN : ST_XMIT;
                end
`ifdef LAYER_SEQ_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_HUNT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            ST_XMIT: begin
                cnt_clr_c = 1'b0;
                cnt_en_c  = 1'b1;
                if (wrap_c) begin
                    if (word_idx_q == LAST_IDX) begin
                        state_d    = ST_FIN;
                        word_idx_d = '0;
                    end else begin
                        word_idx_d = word_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_HUNT;
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    // State plus level outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_HUNT;
            word_idx_q <= '0;
            f_lat_q    <= 1'b0;
            first_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ser_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            f_lat_q    <= f_lat_d;
            first_q    <= first_d;
            busy_q     <= (state_d != ST_HUNT);
            done_q     <= (state_d == ST_FIN);
            ser_en_q   <= (state_d == ST_XMIT);
        end
    end

`ifdef LAYER_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign bus.err_timeout = err_q;
`else
    assign bus.err_timeout = 1'b0;
`endif

    assign bus.st_load  = (state_q == ST_RECV) && wrap_c;
    assign bus.st_start = (state_q == ST_TEST) && first_q;
    assign bus.ser_load = (state_q == ST_XMIT) && (bit_cnt == '0);
    assign bus.ser_en   = ser_en_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.word_idx = word_idx_q;
endmodule

// File: tb/tb_layer_test_seq.sv
// Directed bench for layer_test_seq (WORD_W=32, NUM_WORDS=2, TIMEOUT=16).
module tb_layer_test_seq;
    import layer_test_pkg::*;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned NUM_WORDS = 2;
    localparam logic [31:0] HDR       = 32'hA5A5_5A5A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    layer_test_seq_if #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) bus ();

    layer_test_seq #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS),
`ifdef LAYER_SEQ_TIMEOUT_EN
        .TIMEOUT   (16),
`endif
        .HEADER    (HDR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Event cycles relative to the header at cycle 10; -1 means never.
    typedef struct {
        logic f_layer;
        int   hdr2, sf_a, sf_b;
        int   ld0, ld1, start, sl0, sl1, en_lo, en_hi, done_c, busy_hi, err_lo, run_len;
    } scn_t;

    scn_t tbl [5];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [7:0] outs();
        return {bus.busy, bus.st_load, bus.st_start, bus.ser_load,
                bus.ser_en, bus.done, bus.err_timeout, bus.word_idx};
    endfunction

    task automatic check(input string tag, input int c, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s cyc %0d got %b want %b (busy,ld,start,sload,sen,done,err,idx)",
                         tag, c, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.des_word = '0;
        bus.sort_finish = 1'b0;
        bus.f_layer = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset", -1, outs(), 8'h00);
    endtask

    task automatic run_scn(input int s, input int ncyc);
        logic [7:0] e;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            if (c == 10 || c == tbl[s].hdr2) bus.des_word = HDR;
            else if (c == 5)                 bus.des_word = HDR ^ 32'h1;
            else                             bus.des_word = 32'h1234_0000 | 32'(c);
            bus.sort_finish = (c == tbl[s].sf_a) || (c == tbl[s].sf_b);
            bus.f_layer     = (c == 10) ? tbl[s].f_layer : ~tbl[s].f_layer;
            #1;
            e[7] = (c >= 11) && (c <= tbl[s].busy_hi);
            e[6] = (c == tbl[s].ld0) || (c == tbl[s].ld1);
            e[5] = (c == tbl[s].start);
            e[4] = (c == tbl[s].sl0) || (c == tbl[s].sl1);
            e[3] = (tbl[s].en_lo >= 0) && (c >= tbl[s].en_lo) && (c <= tbl[s].en_hi);
            e[2] = (c == tbl[s].done_c);
            e[1] = (tbl[s].err_lo >= 0) && (c >= tbl[s].err_lo);
            e[0] = ((c > tbl[s].ld0) && (c <= tbl[s].ld1)) ||
                   ((tbl[s].sl1 >= 0) && (c >= tbl[s].sl1) && (c <= tbl[s].en_hi));
            check($sformatf("scn%0d", s), c, outs(), e);
        end
    endtask

    initial begin
        //        f     hdr2 sf_a sf_b ld0 ld1 start sl0 sl1 en_lo en_hi done busy_hi err_lo len
        tbl[0] = '{1'b0, -1,  80,  -1, 42, 74,  75,  81, 113,  81, 144, 145, 145,     -1, 160};
        tbl[1] = '{1'b1, -1,  80,  -1, 42, 74,  75,  -1,  -1,  -1,  -1,  81,  81,     -1, 100};
        tbl[2] = '{1'b0, -1,  75,  90, 42, 74,  75,  91, 123,  91, 154, 155, 155,     -1, 170};
        tbl[3] = '{1'b1, 30,  50,  80, 42, 74,  75,  -1,  -1,  -1,  -1,  81,  81,     -1, 100};
`ifdef LAYER_SEQ_TIMEOUT_EN
        tbl[4] = '{1'b0, -1,  -1,  -1, 42, 74,  75,  -1,  -1,  -1,  -1,  -1,  90,     91, 120};
`else
        tbl[4] = '{1'b0, -1,  -1,  -1, 42, 74,  75,  -1,  -1,  -1,  -1,  -1, 119,     -1, 120};
`endif

        for (int s = 0; s < 5; s++) begin
            do_reset();
            run_scn(s, tbl[s].run_len);
        end

        // Still in the timeout/stall case: a fresh header clears err_timeout.
        @(posedge clk);
        #1;
        bus.des_word = HDR;
        bus.sort_finish = 1'b0;
        @(posedge clk);
        #1;
        bus.des_word = 32'h0;
        #1;
        check("hdr_clears_err", 121, {6'b0, bus.busy, bus.err_timeout}, 8'b0000_0010);

        // Reset in the middle of XMIT, then a clean frame.
        do_reset();
        run_scn(0, 101);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_in_xmit", 101, outs(), 8'h00);
        run_scn(0, tbl[0].run_len);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
